// File: rtl/blk_59eb98_pkg.sv
// Shared definitions for the signed divide-by-power-of-two pipeline.
package blk_59eb98_pkg;

  localparam logic MODE_TRUNCATE = 1'b0;
  localparam logic MODE_FLOOR    = 1'b1;

  // Width-independent part of the stage-1 payload; data fields are sized in the top.
  typedef struct packed {
    logic sticky;
    logic sign;
    logic mode;
    logic clamped;
  } s1_ctrl_t;

endpackage

// File: rtl/blk_59eb98_if.sv
// Valid/ready stream bundle for the divider: request side and result side.
interface blk_59eb98_if #(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned EXP_WIDTH  = 5
);

  logic                  input_valid;
  logic                  input_ready;
  logic [WORD_WIDTH-1:0] numerator;
  logic [EXP_WIDTH-1:0]  exponent_of_two;
  logic                  mode;

  logic                  output_valid;
  logic                  output_ready;
  logic [WORD_WIDTH-1:0] quotient;
  logic [WORD_WIDTH-1:0] remainder;
  logic                  exponent_clamped;

  modport slave (
    input  input_valid, numerator, exponent_of_two, mode, output_ready,
    output input_ready, output_valid, quotient, remainder, exponent_clamped
  );

  modport master (
    output input_valid, numerator, exponent_of_two, mode, output_ready,
    input  input_ready, output_valid, quotient, remainder, exponent_clamped
  );

endinterface

// File: rtl/blk_59eb98_addsub.sv
// Binary adder/subtractor, wrapping modulo 2^WIDTH.
module blk_59eb98_addsub #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] sum_c_o
);

  assign sum_c_o = sub_i ? (a_i - b_i) : (a_i + b_i);

endmodule

// File: rtl/blk_59eb98_shifter.sv
// Arithmetic right shift plus a mask selecting the bits shifted out.
module blk_59eb98_shifter #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned SHAMT_W   = 5
) (
  input  logic [WIDTH-1:0]   data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic [WIDTH-1:0]   quot_c_o,
  output logic [WIDTH-1:0]   mask_c_o
);

  assign quot_c_o = $signed(data_i) >>> shamt_i;
  assign mask_c_o = ~({WIDTH{1'b1}} << shamt_i);

endmodule

// File: rtl/blk_59eb98_stage.sv
// One pipeline slot: valid bit plus payload, loaded on advance, cleared synchronously.
module blk_59eb98_stage #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o
);

  logic          valid_q;
  logic [DW-1:0] data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (en_i) begin
      valid_q <= valid_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/blk_59eb98.sv
// Two-stage signed divide by 2^N: stage 1 shifts, stage 2 applies the truncation correction.
module blk_59eb98
  import blk_59eb98_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned EXP_WIDTH  = 5
) (
  input  logic         clock,
  input  logic         clear_n,
  blk_59eb98_if.slave  bus
);

  typedef struct packed {
    logic [WORD_WIDTH-1:0] floor_q;
    logic [WORD_WIDTH-1:0] low;
    logic [WORD_WIDTH-1:0] pow2;
    s1_ctrl_t              ctrl;
  } s1_payload_t;

  typedef struct packed {
    logic                  clamped;
    logic [WORD_WIDTH-1:0] quot;
    logic [WORD_WIDTH-1:0] rem;
  } s2_payload_t;

  localparam int unsigned S1_W = $bits(s1_payload_t);
  localparam int unsigned S2_W = $bits(s2_payload_t);

  logic                  advance;
  logic                  clamped;
  logic [WORD_WIDTH-1:0] shift_quot;
  logic [WORD_WIDTH-1:0] shift_mask;
  s1_payload_t           s1_d;
  s1_payload_t           s1_q;
  logic                  s1_valid;
  logic [WORD_WIDTH-1:0] quot_inc;
  logic [WORD_WIDTH-1:0] rem_neg;
  s2_payload_t           s2_d;
  s2_payload_t           s2_q;
  logic                  s2_valid;

  // The whole pipeline moves together whenever the output slot is free or being drained.
  assign advance         = !s2_valid || bus.output_ready;
  assign bus.input_ready = advance;

  assign clamped = bus.exponent_of_two >= EXP_WIDTH'(WORD_WIDTH);

  blk_59eb98_shifter #(
    .WIDTH   (WORD_WIDTH),
    .SHAMT_W (EXP_WIDTH)
  ) u_shifter (
    .data_i   (bus.numerator),
    .shamt_i  (bus.exponent_of_two),
    .quot_c_o (shift_quot),
    .mask_c_o (shift_mask)
  );

  // Stage 1: floor quotient, shifted-out bits and the divisor for the later correction.
  always_comb begin
    s1_d              = '0;
    s1_d.ctrl.sign    = bus.numerator[WORD_WIDTH-1];
    s1_d.ctrl.mode    = bus.mode;
    s1_d.ctrl.clamped = clamped;
    s1_d.pow2         = WORD_WIDTH'(1) << bus.exponent_of_two;
    if (clamped) begin
      s1_d.floor_q = {WORD_WIDTH{bus.numerator[WORD_WIDTH-1]}};
      s1_d.low     = bus.numerator;
    end else begin
      s1_d.floor_q = shift_quot;
      s1_d.low     = bus.numerator & shift_mask;
    end
    s1_d.ctrl.sticky = |s1_d.low;
  end

  blk_59eb98_stage #(.DW(S1_W)) u_stage1 (
    .clk     (clock),
    .rst_n   (clear_n),
    .en_i    (advance),
    .valid_i (bus.input_valid),
    .data_i  (s1_d),
    .valid_o (s1_valid),
    .data_o  (s1_q)
  );

  blk_59eb98_addsub #(.WIDTH(WORD_WIDTH)) u_quot_inc (
    .a_i     (s1_q.floor_q),
    .b_i     (WORD_WIDTH'(1)),
    .sub_i   (1'b0),
    .sum_c_o (quot_inc)
  );

  // pow2 is zero for clamped exponents, so the clamped remainder stays the numerator.
  blk_59eb98_addsub #(.WIDTH(WORD_WIDTH)) u_rem_sub (
    .a_i     (s1_q.low),
    .b_i     (s1_q.pow2),
    .sub_i   (1'b1),
    .sum_c_o (rem_neg)
  );

  // Stage 2: round toward zero for inexact negative numerators in truncate mode.
  always_comb begin
    s2_d         = '0;
    s2_d.clamped = s1_q.ctrl.clamped;
    s2_d.quot    = s1_q.floor_q;
    s2_d.rem     = s1_q.low;
    if (s1_q.ctrl.mode == MODE_TRUNCATE && s1_q.ctrl.sign && s1_q.ctrl.sticky) begin
      s2_d.quot = quot_inc;
      s2_d.rem  = rem_neg;
    end
  end

  blk_59eb98_stage #(.DW(S2_W)) u_stage2 (
    .clk     (clock),
    .rst_n   (clear_n),
    .en_i    (advance),
    .valid_i (s1_valid),
    .data_i  (s2_d),
    .valid_o (s2_valid),
    .data_o  (s2_q)
  );

  assign bus.output_valid     = s2_valid;
  assign bus.quotient         = s2_q.quot;
  assign bus.remainder        = s2_q.rem;
  assign bus.exponent_clamped = s2_q.clamped;

endmodule

// File: tb/tb_blk_59eb98.sv
// Self-checking bench for blk_59eb98 at WORD_WIDTH=8, EXP_WIDTH=4.
module tb_blk_59eb98;

  localparam int unsigned W  = 8;
  localparam int unsigned EW = 4;

  logic clock   = 1'b0;
  logic clear_n = 1'b0;

  always #5 clock = ~clock;

  blk_59eb98_if #(.WORD_WIDTH(W), .EXP_WIDTH(EW)) bus();

  blk_59eb98 #(.WORD_WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { int q; int r; int c; } res_t;
  typedef struct { int num; int n; int md; int eq; int er; int ec; } vec_t;
  typedef struct { int num; int n; res_t e; } sb_t;

  vec_t vt[16];
  sb_t  sbq[$];
  int   s_num[4] = '{-100, 55, -1, 90};
  int   s_n[4]   = '{3, 2, 0, 10};
  int   s_md[4]  = '{0, 1, 1, 0};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: integer division semantics straight from the definition.
  function automatic res_t model(input int num, input int n, input int md);
    res_t x;
    int   d;
    x.c = (n >= int'(W)) ? 1 : 0;
    if (x.c == 1) begin
      x.q = (md == 1 && num < 0) ? -1 : 0;
      x.r = num;
    end else begin
      d   = 1 << n;
      x.q = num / d;
      if (md == 1 && num < 0 && (num % d) != 0) x.q = x.q - 1;
      x.r = num - x.q * d;
    end
    return x;
  endfunction

  function automatic int recombine(input logic [7:0] q, input logic [7:0] r, input int n);
    int qs;
    qs = int'($signed(q));
    return (qs * (1 << n) + int'(r)) & 255;
  endfunction

  task automatic drive(input int num, input int n, input int md);
    bus.numerator       = W'(num);
    bus.exponent_of_two = EW'(n);
    bus.mode            = 1'(md);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    string tag;
    tag = $sformatf("vec%0d", idx);
    drive(v.num, v.n, v.md);
    bus.input_valid  = 1'b1;
    bus.output_ready = 1'b1;
    #1;
    chk({tag, "_ready"}, int'(bus.input_ready), 1);
    tick();
    bus.input_valid = 1'b0;
    lat = 1;
    while (!bus.output_valid && lat < 8) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, 2);
    chk({tag, "_quot"}, int'(bus.quotient), v.eq);
    chk({tag, "_rem"}, int'(bus.remainder), v.er);
    chk({tag, "_clamp"}, int'(bus.exponent_clamped), v.ec);
    chk({tag, "_invariant"}, recombine(bus.quotient, bus.remainder, v.n), v.num & 255);
    tick();
  endtask

  initial begin
    int   idx, ngot, stall, stale, sent, cyc;
    bit   seen, acc;
    res_t e;
    sb_t  s;

    vt[0]  = '{-7,   1, 0, 'hFD, 'hFF, 0};
    vt[1]  = '{-7,   1, 1, 'hFC, 'h01, 0};
    vt[2]  = '{7,    2, 0, 'h01, 'h03, 0};
    vt[3]  = '{7,    2, 1, 'h01, 'h03, 0};
    vt[4]  = '{-128, 7, 0, 'hFF, 'h00, 0};
    vt[5]  = '{-5,   9, 1, 'hFF, 'hFB, 1};
    vt[6]  = '{-5,   9, 0, 'h00, 'hFB, 1};
    vt[7]  = '{-77,  0, 0, 'hB3, 'h00, 0};
    vt[8]  = '{-77,  0, 1, 'hB3, 'h00, 0};
    vt[9]  = '{-1,   3, 0, 'h00, 'hFF, 0};
    vt[10] = '{-1,   3, 1, 'hFF, 'h07, 0};
    vt[11] = '{127,  7, 1, 'h00, 'h7F, 0};
    vt[12] = '{0,   15, 0, 'h00, 'h00, 1};
    vt[13] = '{-128, 7, 1, 'hFF, 'h00, 0};
    vt[14] = '{100,  8, 1, 'h00, 'h64, 1};
    vt[15] = '{-128, 8, 0, 'h00, 'h80, 1};

    // Reset state
    bus.input_valid  = 1'b0;
    bus.output_ready = 1'b0;
    drive(0, 0, 0);
    clear_n = 1'b0;
    tick();
    tick();
    chk("rst_valid", int'(bus.output_valid), 0);
    chk("rst_quot", int'(bus.quotient), 0);
    chk("rst_rem", int'(bus.remainder), 0);
    chk("rst_clamp", int'(bus.exponent_clamped), 0);
    chk("rst_ready", int'(bus.input_ready), 1);
    clear_n = 1'b1;
    tick();

    foreach (vt[i]) run_vec(vt[i], i);

    // Back-to-back stream with a 3-cycle output stall
    idx = 0; ngot = 0; stall = 0; seen = 1'b0;
    for (int c = 0; c < 30 && ngot < 4; c++) begin
      if (bus.output_valid && !seen) begin
        seen  = 1'b1;
        stall = 3;
      end
      bus.output_ready = (stall == 0);
      bus.input_valid  = (idx < 4);
      if (idx < 4) drive(s_num[idx], s_n[idx], s_md[idx]);
      #1;
      if (stall > 0) begin
        e = model(s_num[0], s_n[0], s_md[0]);
        chk("stall_ready", int'(bus.input_ready), 0);
        chk("stall_valid", int'(bus.output_valid), 1);
        chk("stall_quot", int'(bus.quotient), e.q & 255);
        chk("stall_rem", int'(bus.remainder), e.r & 255);
        stall--;
      end
      if (bus.output_valid && bus.output_ready) begin
        e = model(s_num[ngot], s_n[ngot], s_md[ngot]);
        chk($sformatf("stream%0d_quot", ngot), int'(bus.quotient), e.q & 255);
        chk($sformatf("stream%0d_rem", ngot), int'(bus.remainder), e.r & 255);
        chk($sformatf("stream%0d_clamp", ngot), int'(bus.exponent_clamped), e.c);
        ngot++;
      end
      acc = bus.input_valid && bus.input_ready;
      tick();
      if (acc) idx++;
    end
    chk("stream_count", ngot, 4);
    bus.input_valid  = 1'b0;
    bus.output_ready = 1'b1;
    repeat (3) tick();
    chk("stream_drained", int'(bus.output_valid), 0);

    // Reset with two transactions in flight
    bus.output_ready = 1'b1;
    bus.input_valid  = 1'b1;
    drive(100, 1, 0);
    tick();
    drive(-90, 2, 0);
    tick();
    bus.input_valid = 1'b0;
    clear_n = 1'b0;
    tick();
    clear_n = 1'b1;
    bus.output_ready = 1'b0;
    #1;
    chk("midrst_valid", int'(bus.output_valid), 0);
    chk("midrst_quot", int'(bus.quotient), 0);
    chk("midrst_rem", int'(bus.remainder), 0);
    chk("midrst_clamp", int'(bus.exponent_clamped), 0);
    chk("midrst_ready", int'(bus.input_ready), 1);
    bus.output_ready = 1'b1;
    stale = 0;
    repeat (5) begin
      tick();
      if (bus.output_valid) stale++;
    end
    chk("midrst_no_stale", stale, 0);

    // Randomized regression against the scoreboard
    sent = 0;
    cyc  = 0;
    while ((sent < 10000 || sbq.size() > 0) && cyc < 60000) begin
      bus.output_ready = ($urandom_range(0, 4) != 0);
      if (sent < 10000 && $urandom_range(0, 4) != 0) begin
        bus.input_valid     = 1'b1;
        bus.numerator       = W'($urandom);
        bus.exponent_of_two = EW'($urandom);
        bus.mode            = 1'($urandom);
      end else begin
        bus.input_valid = 1'b0;
      end
      #1;
      if (bus.output_valid && bus.output_ready) begin
        if (sbq.size() == 0) begin
          chk("rand_unexpected", 1, 0);
        end else begin
          s = sbq.pop_front();
          chk("rand_quot", int'(bus.quotient), s.e.q & 255);
          chk("rand_rem", int'(bus.remainder), s.e.r & 255);
          chk("rand_clamp", int'(bus.exponent_clamped), s.e.c);
          chk("rand_invariant", recombine(bus.quotient, bus.remainder, s.n), s.num & 255);
        end
      end
      if (bus.input_valid && bus.input_ready) begin
        s.num = int'($signed(bus.numerator));
        s.n   = int'(bus.exponent_of_two);
        s.e   = model(s.num, s.n, int'(bus.mode));
        sbq.push_back(s);
        sent++;
      end
      tick();
      cyc++;
    end
    chk("rand_sent", sent, 10000);
    chk("rand_drained", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/blk_59eb98.md
# divider_integer_signed_by_powers_of_two_pipelined

Pipelined signed integer divider by 2^N with a valid/ready handshake on both sides. It supports per-transaction selection of truncating division (toward zero) or floor division (toward minus infinity). Exponents of WORD_WIDTH or more are clamped to defined results and flagged. It sits between streaming producers and consumers in fixed-point datapaths that need scaling with exact quotient and remainder at one result per cycle.

## Interface
- WORD_WIDTH, 16: numerator, quotient and remainder width in bits; must be at least 2.
- EXP_WIDTH, 5: exponent width in bits; must satisfy 2^EXP_WIDTH > WORD_WIDTH.
- clock  input  1  single clock; all logic is on the rising edge.
- clear_n  input  1  synchronous, active-low reset.
- input_valid  input  1  input transaction present.
- input_ready  output  1  block accepts the input this cycle.
- numerator  input  WORD_WIDTH  signed dividend.
- exponent_of_two  input  EXP_WIDTH  unsigned N; divisor is 2^N.
- mode  input  1  0 = truncate, 1 = floor.
- output_valid  output  1  result present.
- output_ready  input  1  consumer accepts the result.
- quotient  output  WORD_WIDTH  signed quotient.
- remainder  output  WORD_WIDTH  truncate: signed, same sign as the numerator. Floor: unsigned value in 0..2^N-1.
- exponent_clamped  output  1  N >= WORD_WIDTH for this result.

## Operation
- Invariant: numerator = quotient*2^N + remainder, modulo 2^WORD_WIDTH.
- Stage 1 (shift), for N < WORD_WIDTH:
  - Arithmetic right shift of the numerator by N gives the floor quotient.
  - Bits shifted out form the low remainder bits.
  - sticky = OR of the shifted-out bits.
- Stage 1, for N >= WORD_WIDTH:
  - Floor quotient = all sign bits.
  - Low remainder bits = the numerator.
  - sticky = (numerator != 0).
  - exponent_clamped = 1.
- Stage 2 (correct):
  - Truncate mode with a negative numerator and sticky = 1: quotient = floor quotient + 1, and remainder = low bits − 2^N, sign-extended.
  - Truncate mode otherwise: remainder = low bits, zero-extended.
  - Floor mode: quotient = floor quotient, remainder = low bits, zero-extended.
- Clamped results:
  - Truncate: quotient = 0, remainder = numerator.
  - Floor: quotient = −1 if negative, else 0; remainder bit pattern = numerator.
- N = 0 passes the numerator through with remainder 0 in both modes.
- Most-negative numerator: truncate with N = WORD_WIDTH−1 gives quotient −1 and remainder 0. No overflow case exists.
- Handshake:
  - advance = !output_valid || output_ready.
  - input_ready = advance.
  - The whole pipeline shifts only on advance.
  - An input is accepted on a cycle with input_valid && input_ready.
  - A bubble (input_valid low while advancing) propagates as an invalid slot.

## Timing
- Latency: 2 cycles from input acceptance to output_valid, when not stalled.
- Throughput: 1 result per cycle with output_ready held high.
- Stall: while output_valid && !output_ready, all outputs and stage registers hold exactly and input_ready = 0.
- input_ready depends combinationally on output_ready. This is the only comb path from input ports to output ports.
- Reset (clear_n low at a clock edge): every stage valid bit = 0; output_valid, quotient, remainder and exponent_clamped = 0. input_ready is 1 during and after reset.
- Reset mid-operation discards in-flight results; none are emitted afterward.
- Simultaneous input acceptance and output consumption is legal and loses nothing.

## Structure
- Shared package divider_pow2_pkg holds:
  - MODE_TRUNCATE = 1'b0, MODE_FLOOR = 1'b1.
  - The stage-1 payload struct: floor quotient, low bits, sticky, sign, mode, clamped.
- Stage 1 instantiates the existing Bit_Shifter; the clamp compare is local logic.
- Stage 2 uses Adder_Subtractor_Binary twice: quotient increment and remainder subtract.
- One natural sub-module: pipeline_stage_valid_register, which holds the valid bit, the payload enable on advance, and the synchronous active-low clear. It is instantiated twice.

## Test plan
All scenarios use WORD_WIDTH=8 and EXP_WIDTH=4.
- −7, N=1, truncate → quotient −3, remainder −1. Same inputs in floor → quotient −4, remainder 1. Check output_valid exactly 2 cycles after acceptance.
- 7, N=2, both modes → quotient 1, remainder 3. Then −128, N=7, truncate → quotient −1, remainder 0.
- −5, N=9, floor → quotient −1, remainder 0xFB, exponent_clamped=1. Same in truncate → quotient 0, remainder −5, exponent_clamped=1.
- Stream 4 back-to-back inputs; hold output_ready low for 3 cycles after the first output_valid:
  - Outputs hold stable and input_ready=0.
  - After release, all 4 results arrive in order with none lost or duplicated.
- Assert clear_n low one cycle while 2 transactions are in flight → output_valid=0 and all outputs 0 the next cycle; no stale results appear later.
- Random regression of 10k inputs across both modes and N in 0..15 against a reference model: quotient, remainder, invariant and clamp flag all match.
